// File: rtl/ahb_tap_pkg.sv
// ahb_tap_pkg
// Shared constants and types for the AHB-lite transaction tap:
//   - HTRANS / HRESP encodings
//   - data-phase tracking FSM state type
//   - wait-state saturation limit and a saturating 8-bit increment
//   - width of the non-address/non-data part of a packed record
package ahb_tap_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam logic [7:0] WAIT_MAX = 8'd255;

    // write(1) + size(3) + burst(3) + prot(4) + resp(1) + waits(8)
    localparam int REC_CTRL_W = 20;

    typedef enum logic {
        PH_IDLE = 1'b0,
        PH_DATA = 1'b1
    } phase_e;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == WAIT_MAX) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/ahb_tap_fifo.sv
// ahb_tap_fifo
// Show-ahead synchronous FIFO holding packed transfer records.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   push, push_data   write request and record; ignored when full unless
//                     a pop happens on the same edge
//   full              occupancy equals DEPTH
//   pop               read request; ignored when empty
//   pop_data          head entry (valid whenever empty=0)
//   empty             no entries
//   level             current occupancy, 0..DEPTH
module ahb_tap_fifo
    import ahb_tap_pkg::*;
#(
    parameter int WIDTH = 86,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    output logic                     full,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW    = $clog2(DEPTH);
    localparam int LVL_W = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] count_q,  count_d;
    logic             push_ok, pop_ok;

    assign full     = (count_q == LVL_W'(DEPTH));
    assign empty    = (count_q == '0);
    assign level    = count_q;
    assign pop_data = mem_q[rd_ptr_q];

    always_comb begin
        pop_ok   = pop & ~empty;
        // A pop on the same edge frees the slot, so a push into a full FIFO still lands.
        push_ok  = push & (~full | pop_ok);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + LVL_W'(1);
            2'b01:   count_d = count_q - LVL_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: nothing is visible until count_q says so.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/ahb_txn_tap.sv
// ahb_txn_tap
// Passive AHB-lite monitor. Pairs every accepted address phase with its
// data phase and queues one completed-transfer record per transfer.
// Never drives the bus.
// Ports:
//   HCLK, HRESET            bus clock, asynchronous active-low reset
//   HSEL..HRESP             observed AHB-lite signals (inputs only)
//   txn_valid/txn_ready     record stream handshake (show-ahead head)
//   txn_addr..txn_waits     head record fields; all zero while empty
//   ovf_clr                 clears overflow and drop_cnt
//   overflow, drop_cnt      sticky drop flag, saturating drop counter
//   level                   record FIFO occupancy
//
// state   | meaning
// PH_IDLE | no address phase outstanding
// PH_DATA | address accepted, waiting for its data phase to complete
module ahb_txn_tap
    import ahb_tap_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int SEL_W  = 2,
    parameter int DEPTH  = 8
) (
    input  logic                   HCLK,
    input  logic                   HRESET,
    input  logic [SEL_W-1:0]       HSEL,
    input  logic [ADDR_W-1:0]      HADDR,
    input  logic                   HWRITE,
    input  logic [2:0]             HSIZE,
    input  logic [2:0]             HBURST,
    input  logic [3:0]             HPROT,
    input  logic [1:0]             HTRANS,
    input  logic [DATA_W-1:0]      HWDATA,
    input  logic [DATA_W-1:0]      HRDATA,
    input  logic                   HREADY,
    input  logic                   HRESP,
    input  logic                   txn_ready,
    output logic                   txn_valid,
    output logic [ADDR_W-1:0]      txn_addr,
    output logic                   txn_write,
    output logic [2:0]             txn_size,
    output logic [2:0]             txn_burst,
    output logic [3:0]             txn_prot,
    output logic [SEL_W-1:0]       txn_sel,
    output logic [DATA_W-1:0]      txn_data,
    output logic                   txn_resp,
    output logic [7:0]             txn_waits,
    input  logic                   ovf_clr,
    output logic                   overflow,
    output logic [7:0]             drop_cnt,
    output logic [$clog2(DEPTH):0] level
);

    localparam int REC_W = ADDR_W + DATA_W + SEL_W + REC_CTRL_W;

    phase_e            state_q, state_d;
    logic [ADDR_W-1:0] pend_addr_q,  pend_addr_d;
    logic              pend_write_q, pend_write_d;
    logic [2:0]        pend_size_q,  pend_size_d;
    logic [2:0]        pend_burst_q, pend_burst_d;
    logic [3:0]        pend_prot_q,  pend_prot_d;
    logic [SEL_W-1:0]  pend_sel_q,   pend_sel_d;
    logic [7:0]        wait_q,       wait_d;
    logic              overflow_q,   overflow_d;
    logic [7:0]        drop_cnt_q,   drop_cnt_d;

    logic              trans_active;
    logic              addr_acc;
    logic              rec_push;
    logic              rec_pop;
    logic              drop;
    logic [DATA_W-1:0] rec_data;
    logic              rec_resp;
    logic [REC_W-1:0]  rec_wdata;
    logic [REC_W-1:0]  fifo_rd_data;
    logic [REC_W-1:0]  head_rec;
    logic              fifo_full;
    logic              fifo_empty;

    always_comb begin
        case (HTRANS)
            HTRANS_NONSEQ, HTRANS_SEQ: trans_active = 1'b1;
            HTRANS_IDLE, HTRANS_BUSY:  trans_active = 1'b0;
            default:                   trans_active = 1'b0;
        endcase
    end

    assign addr_acc = HREADY & trans_active & (|HSEL);
    assign rec_data = pend_write_q ? HWDATA : HRDATA;
    assign rec_resp = (HRESP == HRESP_ERROR);

    always_comb begin
        state_d      = state_q;
        pend_addr_d  = pend_addr_q;
        pend_write_d = pend_write_q;
        pend_size_d  = pend_size_q;
        pend_burst_d = pend_burst_q;
        pend_prot_d  = pend_prot_q;
        pend_sel_d   = pend_sel_q;
        wait_d       = wait_q;
        rec_push     = 1'b0;

        case (state_q)
            PH_IDLE: begin
                if (addr_acc) begin
                    state_d = PH_DATA;
                end
            end
            PH_DATA: begin
                if (!HREADY) begin
                    wait_d = sat_inc8(wait_q);
                end else begin
                    rec_push = 1'b1;
                    // Pipelined AHB: the completing edge may also carry the next address.
                    state_d  = addr_acc ? PH_DATA : PH_IDLE;
                end
            end
            default: state_d = PH_IDLE;
        endcase

        // The pending register is only overwritten on an accept, which needs
        // HREADY=1, i.e. after the record above has already been built.
        if (addr_acc) begin
            pend_addr_d  = HADDR;
            pend_write_d = HWRITE;
            pend_size_d  = HSIZE;
            pend_burst_d = HBURST;
            pend_prot_d  = HPROT;
            pend_sel_d   = HSEL;
            wait_d       = 8'd0;
        end
    end

    assign rec_wdata = {pend_addr_q, rec_data, pend_sel_q, pend_write_q, pend_size_q,
                        pend_burst_q, pend_prot_q, rec_resp, wait_q};

    assign txn_valid = ~fifo_empty;
    assign rec_pop   = txn_valid & txn_ready;
    assign drop      = rec_push & fifo_full & ~rec_pop;

    always_comb begin
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        // A drop on the clearing edge must stay visible, so it beats ovf_clr.
        if (drop) begin
            overflow_d = 1'b1;
            drop_cnt_d = ovf_clr ? 8'd1 : sat_inc8(drop_cnt_q);
        end else if (ovf_clr) begin
            overflow_d = 1'b0;
            drop_cnt_d = 8'd0;
        end
    end

    always_ff @(posedge HCLK or negedge HRESET) begin
        if (!HRESET) begin
            state_q      <= PH_IDLE;
            pend_addr_q  <= '0;
            pend_write_q <= 1'b0;
            pend_size_q  <= '0;
            pend_burst_q <= '0;
            pend_prot_q  <= '0;
            pend_sel_q   <= '0;
            wait_q       <= '0;
            overflow_q   <= 1'b0;
            drop_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            pend_addr_q  <= pend_addr_d;
            pend_write_q <= pend_write_d;
            pend_size_q  <= pend_size_d;
            pend_burst_q <= pend_burst_d;
            pend_prot_q  <= pend_prot_d;
            pend_sel_q   <= pend_sel_d;
            wait_q       <= wait_d;
            overflow_q   <= overflow_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    ahb_tap_fifo #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (HCLK),
        .rst_n     (HRESET),
        .push      (rec_push),
        .push_data (rec_wdata),
        .full      (fifo_full),
        .pop       (rec_pop),
        .pop_data  (fifo_rd_data),
        .empty     (fifo_empty),
        .level     (level)
    );

    // FIFO storage is not reset, so the head is masked to zero while empty.
    assign head_rec = fifo_empty ? '0 : fifo_rd_data;
    assign {txn_addr, txn_data, txn_sel, txn_write, txn_size,
            txn_burst, txn_prot, txn_resp, txn_waits} = head_rec;

    assign overflow = overflow_q;
    assign drop_cnt = drop_cnt_q;

endmodule

// File: doc/ahb_txn_tap.md
# ahb_txn_tap

Passive, parametrised AHB-lite transaction tap: observes the bus between master and memory slave and pairs each accepted address phase with its data phase. It emits one completed-transfer record per transfer through a valid/ready stream backed by an internal FIFO. It sits beside the DUT in the verification environment, feeding scoreboards and coverage, and never drives the bus.

## Interface
Parameters:
- ADDR_W, 32, HADDR width
- DATA_W, 32, HWDATA/HRDATA width
- SEL_W, 2, HSEL width
- DEPTH, 8, record FIFO depth (power of two, ≥2)

Ports:
- HCLK  in  1  bus clock; all state on rising edge
- HRESET  in  1  asynchronous, active-low reset
- HSEL  in  SEL_W  slave selects
- HADDR  in  ADDR_W  address
- HWRITE  in  1  direction
- HSIZE  in  3  transfer size
- HBURST  in  3  burst type
- HPROT  in  4  protection
- HTRANS  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3
- HWDATA  in  DATA_W  write data
- HRDATA  in  DATA_W  read data
- HREADY  in  1  bus ready
- HRESP  in  1  0=OKAY, 1=ERROR
- txn_ready  in  1  consumer accepts head record
- txn_valid  out  1  head record valid
- txn_addr  out  ADDR_W; txn_write  out  1; txn_size  out  3; txn_burst  out  3; txn_prot  out  4; txn_sel  out  SEL_W
- txn_data  out  DATA_W  HWDATA for writes, HRDATA for reads
- txn_resp  out  1  HRESP at completion
- txn_waits  out  8  wait-state count, saturating at 255
- ovf_clr  in  1  clears overflow and drop_cnt
- overflow  out  1  sticky: a record was dropped
- drop_cnt  out  8  dropped records, saturating at 255
- level  out  $clog2(DEPTH)+1  FIFO occupancy

## Operation
- Address accept: a rising edge with HREADY=1, HTRANS∈{NONSEQ,SEQ}, and |HSEL=1. On that edge, latch addr/write/size/burst/prot/sel into the pending register and enter DATA. IDLE and BUSY are never recorded.
- Phase FSM, two states:
  - IDLE: no pending transfer. Go to DATA on address accept.
  - DATA: each edge with HREADY=0 increments the wait counter, saturating at 255.
  - DATA, edge with HREADY=1: the data phase completes. Data is sampled as HWRITE_latched ? HWDATA : HRDATA, resp as HRESP, and the record is pushed.
  - On completion, go to DATA if the same edge also accepts a new address (pipelined back-to-back), otherwise to IDLE. The wait counter is cleared on every accept.
- ERROR response: the first ERROR cycle (HREADY=0) counts as a wait. The record's resp=1 comes from the completing cycle.
- FIFO: show-ahead; the head is always presented on txn_*. A pop happens on an edge with txn_valid & txn_ready.
- Push while full without a simultaneous pop: the record is dropped, overflow is set, and drop_cnt increments.
- Push and pop on the same edge when full: both succeed, and level is unchanged.
- ovf_clr on an edge clears overflow and drop_cnt. A drop on the same edge wins: overflow=1, drop_cnt=1.

## Timing
- Reset values: FSM IDLE, FIFO empty, txn_valid=0, all txn_* =0, overflow=0, drop_cnt=0, level=0.
- Reset asserted mid-transfer discards the pending transfer and all FIFO contents immediately; nothing is emitted for it.
- Latency: a record pushed on completion edge N is visible on txn_* after edge N, i.e. in cycle N+1, when the FIFO was empty.
- Stream rules: txn_* stay stable while txn_valid=1 and txn_ready=0. txn_ready has no combinational path to any output except through registered state.
- Sustained throughput: one record per cycle for zero-wait back-to-back transfers.

## Structure
- Package ahb_tap_pkg:
  - HTRANS constants (IDLE, BUSY, NONSEQ, SEQ) and HRESP constants (OKAY, ERROR)
  - phase FSM enum
  - WAIT_MAX=255
- Sub-module ahb_tap_fifo: synchronous FIFO, parametrised width and DEPTH.
  - Interfaces: push/full, pop/empty, level, same-edge push+pop when full.
  - The record is packed into one vector of width ADDR_W+DATA_W+SEL_W+20.

## Test plan
- Single NONSEQ write, addr 0x100, HWDATA 0xDEADBEEF, zero waits -> one record: write=1, data 0xDEADBEEF, resp=0, waits=0; valid in the cycle after completion.
- Read of 0x204 with 3 HREADY=0 cycles, HRDATA 0x12345678 -> data 0x12345678, waits=3.
- Four-beat INCR4 SEQ burst, back-to-back, txn_ready=1 -> 4 records in consecutive cycles, addrs 0x0/0x4/0x8/0xC, burst=3.
- ERROR response (HRESP=1 with HREADY 0 then 1) -> resp=1, waits=1. IDLE/BUSY cycles interleaved in the burst produce no records.
- txn_ready=0, DEPTH+2 transfers -> level=DEPTH, overflow=1, drop_cnt=2; ovf_clr -> both 0. Then txn_ready=1 drains exactly DEPTH records in order.
- HRESET pulled low during a waited data phase with 3 records queued -> txn_valid=0 and level=0 immediately; after release, the first new transfer produces a record with waits counted from 0.
